pwm_duty_sequencer: RTL and testbench



---
 rtl/pwm_pkg.sv | 39 +++
 rtl/pwm_duty_sequencer.sv | 120 ++++++++++++
 tb/tb_pwm_duty_sequencer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty sequencer.
// step_toward() is the single clamped-step primitive used by both ramping and soft-stop.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        HOLD,
        STOP
    } seq_state_t;

    localparam int PWM_N  = 8;
    localparam int STEP_W = 32;

    // One step of at most 'rate' from cur toward tgt; never overshoots tgt.
    // The difference is formed one bit wider than the operands so it cannot overflow.
    function automatic logic [STEP_W-1:0] step_toward(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] tgt,
        input logic [STEP_W-1:0] rate
    );
        logic [STEP_W:0]   diff;
        logic [STEP_W-1:0] result;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
        end
        if (diff <= {1'b0, rate}) begin
            result = tgt;
        end else if (tgt >= cur) begin
            result = cur + rate;
        end else begin
            result = cur - rate;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_duty_sequencer.sv
// Owns the PWM duty word: accepts target commands and slews duty toward them,
// updating only on PWM period boundaries, with soft-stop back down to zero.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int N         = PWM_N,
    parameter int R         = 4,
    parameter int STOP_RATE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         period_start,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [N-1:0] cmd_target,
    input  logic [R-1:0] cmd_rate,
    input  logic         stop,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         done
);

    seq_state_t   r_state;
    logic [N-1:0] r_duty;
    logic [N-1:0] r_target;
    logic [R-1:0] r_rate;
    logic         r_busy;
    logic         r_done;

    seq_state_t   w_next_state;
    logic [N-1:0] w_next_duty;
    logic [N-1:0] w_next_target;
    logic [R-1:0] w_next_rate;
    logic         w_next_done;
    logic         w_cmd_ready;
    logic         w_accept;
    logic [R-1:0] w_rate_in;
    logic [N-1:0] w_ramp_next;
    logic [N-1:0] w_stop_next;

    assign w_cmd_ready = ena & ~stop & ((r_state == IDLE) | (r_state == HOLD));
    assign w_accept    = cmd_valid & w_cmd_ready;
    assign w_rate_in   = (cmd_rate == '0) ? R'(1) : cmd_rate;

    assign w_ramp_next = N'(step_toward(STEP_W'(r_duty), STEP_W'(r_target), STEP_W'(r_rate)));
    assign w_stop_next = N'(step_toward(STEP_W'(r_duty), '0, STEP_W'(STOP_RATE)));

    always_comb begin
        w_next_state  = r_state;
        w_next_duty   = r_duty;
        w_next_target = r_target;
        w_next_rate   = r_rate;
        w_next_done   = 1'b0;
        case (r_state)
            IDLE, HOLD: begin
                // stop outranks a same-cycle command; IDLE ignores stop entirely
                if ((r_state == HOLD) && ena && stop) begin
                    w_next_state = STOP;
                end else if (w_accept) begin
                    w_next_target = cmd_target;
                    w_next_rate   = w_rate_in;
                    if (cmd_target == r_duty) begin
                        w_next_state = HOLD;
                        w_next_done  = 1'b1;
                    end else begin
                        w_next_state = RAMP;
                    end
                end
            end
            RAMP: begin
                if (ena && stop) begin
                    w_next_state = STOP;
                end else if (ena && period_start) begin
                    w_next_duty = w_ramp_next;
                    if (w_ramp_next == r_target) begin
                        w_next_state = HOLD;
                        w_next_done  = 1'b1;
                    end
                end
            end
            STOP: begin
                if (ena && period_start) begin
                    w_next_duty = w_stop_next;
                    if (w_stop_next == '0) begin
                        w_next_state = IDLE;
                        w_next_done  = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_rate   <= R'(1);
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_duty   <= w_next_duty;
            r_target <= w_next_target;
            r_rate   <= w_next_rate;
            r_busy   <= (w_next_state == RAMP) || (w_next_state == STOP);
            r_done   <= w_next_done;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign duty      = r_duty;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pwm_duty_sequencer;

    localparam int N         = 8;
    localparam int R         = 4;
    localparam int STOP_RATE = 1;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_HOLD = 2;
    localparam int M_STOP = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         ena = 1'b0;
    logic         period_start = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] cmd_target = '0;
    logic [R-1:0] cmd_rate = '0;
    logic         cmd_ready;
    logic [N-1:0] duty;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    int m_mode = M_IDLE;
    int m_duty = 0;
    int m_tgt  = 0;
    int m_rate = 1;
    bit m_done = 1'b0;

    pwm_duty_sequencer #(.N(N), .R(R), .STOP_RATE(STOP_RATE)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .period_start (period_start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_rate     (cmd_rate),
        .stop         (stop),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_ready();
        return int'(ena && !stop && (m_mode == M_IDLE || m_mode == M_HOLD));
    endfunction

    // Behavioural model: plain integer arithmetic on the documented rules.
    always @(posedge clk) begin
        int nm, nd, nt, nr;
        bit ndone;
        nm = m_mode; nd = m_duty; nt = m_tgt; nr = m_rate; ndone = 1'b0;
        if (rst) begin
            nm = M_IDLE; nd = 0; nt = 0; nr = 1;
        end else if (ena) begin
            if (cmd_valid && model_ready() != 0) begin
                nt = int'(cmd_target);
                nr = (cmd_rate == 0) ? 1 : int'(cmd_rate);
                if (nt == m_duty) begin
                    nm = M_HOLD; ndone = 1'b1;
                end else begin
                    nm = M_RAMP;
                end
            end else if (stop && (m_mode == M_RAMP || m_mode == M_HOLD)) begin
                nm = M_STOP;
            end else if (period_start && m_mode == M_RAMP) begin
                if (m_tgt > m_duty) nd = (m_duty + m_rate < m_tgt) ? m_duty + m_rate : m_tgt;
                else                nd = (m_duty - m_rate > m_tgt) ? m_duty - m_rate : m_tgt;
                if (nd == m_tgt) begin
                    nm = M_HOLD; ndone = 1'b1;
                end
            end else if (period_start && m_mode == M_STOP) begin
                nd = (m_duty > STOP_RATE) ? m_duty - STOP_RATE : 0;
                if (nd == 0) begin
                    nm = M_IDLE; ndone = 1'b1;
                end
            end
        end
        m_mode <= nm;
        m_duty <= nd;
        m_tgt  <= nt;
        m_rate <= nr;
        m_done <= ndone;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("duty", int'(duty), m_duty);
            check("busy", int'(busy), int'(m_mode == M_RAMP || m_mode == M_STOP));
            check("done", int'(done), int'(m_done));
            check("cmd_ready", int'(cmd_ready), model_ready());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_period(input int gap);
        repeat (gap) tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic wait_done(input int maxp, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < maxp && !seen; i++) begin
            pulse_period(3);
            if (done) seen = 1'b1;
        end
        check(nm, int'(seen), 1);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1;
        tick(); tick();
        rst = 1'b0; cmp_on = 1'b1;
        check("rst_duty", int'(duty), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);

        // Ramp 0 -> 0x40 by 8, period every 10 cycles
        cmd_valid = 1'b1; cmd_target = 8'h40; cmd_rate = 4'h8;
        tick();
        cmd_valid = 1'b0;
        check("t1_accept_busy", int'(busy), 1);
        check("t1_accept_duty", int'(duty), 0);
        for (int k = 0; k < 8; k++) begin
            pulse_period(9);
            check("t1_step", int'(duty), 8 * (k + 1));
        end
        check("t1_done", int'(done), 1);
        check("t1_busy_fall", int'(busy), 0);
        tick();
        check("t1_done_clear", int'(done), 0);

        // Downward clamp 0x40 -> 0x3A with rate 15
        cmd_valid = 1'b1; cmd_target = 8'h3A; cmd_rate = 4'hF;
        tick();
        cmd_valid = 1'b0;
        pulse_period(4);
        check("t2_clamp", int'(duty), 'h3A);
        check("t2_done", int'(done), 1);

        // Reach 0xFD, then rate 0 treated as 1 up to 0xFF
        cmd_valid = 1'b1; cmd_target = 8'hFD; cmd_rate = 4'hF;
        tick();
        cmd_valid = 1'b0;
        wait_done(20, "t3_reach_fd");
        check("t3_at_fd", int'(duty), 'hFD);
        cmd_valid = 1'b1; cmd_target = 8'hFF; cmd_rate = 4'h0;
        tick();
        cmd_valid = 1'b0;
        pulse_period(2);
        check("t3_fe", int'(duty), 'hFE);
        check("t3_no_done", int'(done), 0);
        pulse_period(2);
        check("t3_ff", int'(duty), 'hFF);
        check("t3_done", int'(done), 1);

        // cmd_valid held through a ramp is taken on the first HOLD cycle
        cmd_valid = 1'b1; cmd_target = 8'hF0; cmd_rate = 4'h4;
        tick();
        cmd_target = 8'h04; cmd_rate = 4'hF;
        check("t4_ready_low", int'(cmd_ready), 0);
        for (int k = 0; k < 4; k++) pulse_period(3);
        check("t4_at_f0", int'(duty), 'hF0);
        check("t4_done", int'(done), 1);
        check("t4_ready_hold", int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        check("t4_queued_accept", int'(busy), 1);
        wait_done(20, "t4_ramp_down");
        check("t4_at_04", int'(duty), 'h04);

        // Soft-stop from 0x04 beats a same-cycle command
        stop = 1'b1; cmd_valid = 1'b1; cmd_target = 8'h80; cmd_rate = 4'h1;
        #1;
        check("t5_ready_low", int'(cmd_ready), 0);
        tick();
        stop = 1'b0; cmd_valid = 1'b0;
        check("t5_stop_busy", int'(busy), 1);
        check("t5_duty_hold", int'(duty), 'h04);
        for (int k = 0; k < 4; k++) begin
            pulse_period(2);
            check("t5_stop_step", int'(duty), 3 - k);
        end
        check("t5_done", int'(done), 1);
        check("t5_idle", int'(busy), 0);
        #1;
        check("t5_ready_idle", int'(cmd_ready), 1);

        // Freeze with ena low, then reset mid-ramp
        cmd_valid = 1'b1; cmd_target = 8'h40; cmd_rate = 4'h8;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) pulse_period(3);
        check("t6_at_20", int'(duty), 'h20);
        ena = 1'b0;
        for (int i = 0; i < 30; i++) begin
            period_start = (i % 5 == 0);
            tick();
        end
        period_start = 1'b0;
        check("t6_frozen", int'(duty), 'h20);
        check("t6_frozen_busy", int'(busy), 1);
        ena = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_duty", int'(duty), 0);
        check("t6_rst_busy", int'(busy), 0);
        #1;
        check("t6_rst_ready", int'(cmd_ready), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            ena          = ($urandom_range(0, 9) != 0);
            period_start = ($urandom_range(0, 4) == 0);
            cmd_valid    = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       cmd_target = '0;
                1:       cmd_target = '1;
                default: cmd_target = N'($urandom);
            endcase
            cmd_rate = R'($urandom);
            stop     = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
